// File: rtl/unidad_logica_reg.sv
// unidad_logica_reg: registered bitwise logic unit with a one-deep output
// register, valid/ready handshake, accumulator feedback and transfer counter.
//
// Handshake: an input is accepted when in_valid && in_ready, where
// in_ready = !out_valid || out_ready; an output transfer happens when
// out_valid && out_ready. Both may occur in the same cycle (full throughput).
//
// Optional macro FLAGS_EN adds registered zero_flag / parity_flag outputs.
module unidad_logica_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_en,
  input  logic             acc_clr,
  output logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] op_count
`ifdef FLAGS_EN
  ,
  output logic             zero_flag,
  output logic             parity_flag
`endif
);

  logic [WIDTH-1:0] y_q, y_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] beff;
  logic [WIDTH-1:0] result;
  logic             accept;
  logic             xfer;

  assign in_ready  = !valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign xfer      = valid_q && out_ready;
  assign y         = y_q;
  assign out_valid = valid_q;
  assign op_count  = cnt_q;

  // Effective operand B: direct input, accumulator, or zero when clearing
  always_comb begin
    beff = b;
    if (acc_en) begin
      beff = acc_clr ? '0 : acc_q;
    end
  end

  // Bitwise operation select
  always_comb begin
    result = '0;
    unique case (op)
      3'd0: result = a & beff;
      3'd1: result = ~(a & beff);
      3'd2: result = a | beff;
      3'd3: result = ~(a | beff);
      3'd4: result = ~a;
      3'd5: result = a ^ beff;
      3'd6: result = ~(a ^ beff);
      3'd7: result = a;
      default: result = '0;
    endcase
  end

  // Next-state: output register, accumulator and transfer counter
  always_comb begin
    y_d     = y_q;
    valid_d = valid_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q + CNT_W'(xfer);
    if (accept) begin
      y_d     = result;
      valid_d = 1'b1;
      acc_d   = result;
    end else begin
      if (xfer) begin
        valid_d = 1'b0;
      end
      if (acc_clr) begin
        acc_d = '0;
      end
    end
  end

  // State registers, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q     <= '0;
      valid_q <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FLAGS_EN
  logic zero_q, parity_q;

  // Result flags, loaded alongside y on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q   <= 1'b0;
      parity_q <= 1'b0;
    end else if (accept) begin
      zero_q   <= (result == '0);
      parity_q <= ^result;
    end
  end

  assign zero_flag   = zero_q;
  assign parity_flag = parity_q;
`endif

endmodule

// File: tb/tb_unidad_logica_reg.sv
// Testbench for unidad_logica_reg (WIDTH=8, CNT_W=4).
module tb_unidad_logica_reg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             acc_en;
  logic             acc_clr;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] op_count;
`ifdef FLAGS_EN
  logic             zero_flag;
  logic             parity_flag;
`endif

  unidad_logica_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .op         (op),
    .acc_en     (acc_en),
    .acc_clr    (acc_clr),
    .y          (y),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .op_count   (op_count)
`ifdef FLAGS_EN
    ,
    .zero_flag  (zero_flag),
    .parity_flag(parity_flag)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model state (transaction level)
  logic [WIDTH-1:0] m_y;
  logic             m_valid;
  logic [WIDTH-1:0] m_acc;
  int               m_transfers;
  logic [WIDTH-1:0] exp_q[$];

  function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] o,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] bv);
    case (o)
      3'd0: return x & bv;
      3'd1: return ~(x & bv);
      3'd2: return x | bv;
      3'd3: return ~(x | bv);
      3'd4: return ~x;
      3'd5: return x ^ bv;
      3'd6: return ~(x ^ bv);
      default: return x;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_y         = '0;
    m_valid     = 1'b0;
    m_acc       = '0;
    m_transfers = 0;
    exp_q.delete();
  endtask

  // Driver: called at negedge with inputs already set. Checks outputs,
  // advances the model across the next rising edge, returns at negedge.
  task automatic step();
    logic             exp_rdy;
    logic             acc_ok;
    logic             xf;
    logic [WIDTH-1:0] bv;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] front;
    #1;
    exp_rdy = !m_valid || out_ready;
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, m_valid);
    chk("y", y, m_y);
    chk("op_count", op_count, m_transfers % (1 << CNT_W));
`ifdef FLAGS_EN
    chk("zero_flag", zero_flag, (m_y == 0));
    chk("parity_flag", parity_flag, ^m_y);
`endif
    acc_ok = in_valid && exp_rdy;
    xf     = m_valid && out_ready;
    if (xf) begin
      front = exp_q.pop_front();
      chk("sb_transfer", y, front);
      m_transfers++;
    end
    if (acc_ok) begin
      bv  = !acc_en ? b : (acc_clr ? '0 : m_acc);
      res = ref_op(op, a, bv);
      exp_q.push_back(res);
      m_y     = res;
      m_valid = 1'b1;
      m_acc   = res;
    end else begin
      if (xf) m_valid = 1'b0;
      if (acc_clr) m_acc = '0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [WIDTH-1:0] av,
                       input logic [WIDTH-1:0] bv, input logic ae, input logic ac,
                       input logic rdy);
    in_valid  = v;
    op        = o;
    a         = av;
    b         = bv;
    acc_en    = ae;
    acc_clr   = ac;
    out_ready = rdy;
    step();
  endtask

  logic [WIDTH-1:0] basic_tbl [8];
  int               cnt_start;

  initial begin
    basic_tbl = '{8'h30, 8'hCF, 8'hFC, 8'h03, 8'h0F, 8'hCC, 8'h33, 8'hF0};
    rst = 1'b1;
    in_valid = 0; a = 0; b = 0; op = 0; acc_en = 0; acc_clr = 0; out_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_y", y, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_count", op_count, 0);
    rst = 1'b0;

    // Basic ops back to back, full throughput
    for (int k = 0; k < 8; k++) begin
      drive(1, 3'(k), 8'hF0, 8'h3C, 0, 0, 1);
      chk("basic_y", y, basic_tbl[k]);
      chk("basic_valid", out_valid, 1);
    end
    drive(0, 0, 0, 0, 0, 0, 1);

    // Backpressure
    drive(1, 3'd0, 8'hFF, 8'h0F, 0, 0, 1);
    chk("bp_first", y, 8'h0F);
    for (int k = 0; k < 5; k++) begin
      drive(1, 3'd2, 8'h80, 8'h01, 0, 0, 0);
      chk("bp_hold", y, 8'h0F);
    end
    drive(1, 3'd2, 8'h80, 8'h01, 0, 0, 1);
    chk("bp_second", y, 8'h81);
    drive(0, 0, 0, 0, 0, 0, 1);

    // Accumulator chain: clear alone, then OR-accumulate
    drive(0, 0, 0, 0, 0, 1, 1);
    drive(1, 3'd2, 8'h01, 8'hAA, 1, 0, 1);
    chk("acc1", y, 8'h01);
    drive(1, 3'd2, 8'h02, 8'hAA, 1, 0, 1);
    chk("acc2", y, 8'h03);
    drive(1, 3'd2, 8'h04, 8'hAA, 1, 0, 1);
    chk("acc3", y, 8'h07);
    drive(1, 3'd2, 8'h10, 8'hAA, 1, 1, 1);
    chk("acc_clr", y, 8'h10);
    drive(1, 3'd2, 8'h20, 8'hAA, 1, 0, 1);
    chk("acc_after", y, 8'h30);

    // Reset mid-backpressure with y=0x30 held
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("pre_rst_y", y, 8'h30);
    rst = 1'b1;
    #1;
    chk("async_rst_y", y, 0);
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_count", op_count, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    // Accumulator must be zero: XOR with acc gives a unchanged
    drive(1, 3'd5, 8'h5C, 8'hFF, 1, 0, 0);
    chk("post_rst_acc", y, 8'h5C);
    drive(0, 0, 0, 0, 0, 0, 1);

    // Counter wrap: 16 more transfers return to the same value, 17th adds 1
    cnt_start = m_transfers;
    for (int k = 0; k < 16; k++) begin
      drive(1, 3'd7, 8'(k), 0, 0, 0, 1);
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("wrap16", op_count, 4'(cnt_start + 16));
    chk("wrap16_eq", op_count, 4'(cnt_start));
    drive(1, 3'd7, 8'h11, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("wrap17", op_count, 4'(cnt_start + 1));

`ifdef FLAGS_EN
    drive(1, 3'd5, 8'h5A, 8'h5A, 0, 0, 1);
    chk("zf_xor", zero_flag, 1);
    chk("pf_xor", parity_flag, 0);
    drive(1, 3'd7, 8'h07, 8'h00, 0, 0, 1);
    chk("zf_pass", zero_flag, 0);
    chk("pf_pass", parity_flag, 1);
`endif

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
            8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) != 0));
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
